qam16_upsampler: RTL and testbench
==================================

Name: qam16_upsampler

Overview:
- Transmit-side sample-rate expander for the QAM16 chain. It takes one signed 4-bit symbol component per symbol period and emits FACTOR output samples per symbol, in zero-stuff or sample-hold mode.
- It drives a phase counter that runs 1..FACTOR, with the symbol sample on count==1. This matches the receive-side decimator, which captures on count==1.
- A one-entry input buffer with a valid/ready handshake decouples the symbol source from the sample rate.

Parameters:
- WIDTH, 4, sample width (signed).
- FACTOR, 4, upsampling ratio; legal range 2..15.
- CNT_W, 4, width of the phase counter; must hold FACTOR.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  block enable; low = synchronous flush.
- mode  input  1  0 = zero-stuff, 1 = sample-hold.
- in_valid  input  1  data_in holds a symbol.
- data_in  input  WIDTH  signed symbol component.
- in_ready  output  1  buffer can accept; equals enable && !buf_full.
- data_up  output  WIDTH  signed upsampled sample (registered).
- out_valid  output  1  data_up is a live sample (registered).
- count  output  CNT_W  phase, 1..FACTOR while running, 0 when idle (registered).
- underrun  output  1  one-cycle pulse: period ended with no next symbol (registered).

Behaviour:
- Internal state:
  - buf_data / buf_full: one-entry input buffer.
  - sym: current symbol.
  - mode_r: mode latched per symbol.
  - state: IDLE or RUN.
- Reset (rst=1, priority over everything):
  - state=IDLE.
  - buf_full=0, buf_data=0, sym=0, mode_r=0.
  - count=0, data_up=0, out_valid=0, underrun=0.
- enable=0 (rst=0): same clearing as reset on the next edge. in_ready=0 meanwhile; no symbol accepted.
- Accept: in_valid && in_ready at an edge sets buf_data=data_in, buf_full=1.
  - Accept and consume never coincide: consume requires buf_full, and then in_ready=0.
- IDLE:
  - Outputs held at count=0, data_up=0, out_valid=0.
  - If enable && buf_full, the next edge does a symbol load:
    - state=RUN, count=1, data_up=buf_data, out_valid=1;
    - sym=buf_data, mode_r=mode, buf_full=0.
- RUN, count<FACTOR:
  - count=count+1, out_valid=1.
  - data_up = sym if mode_r=1, else 0.
- RUN, count==FACTOR (wrap):
  - If buf_full: symbol load as above, count=1. Output is continuous, no gap.
  - Else: state=IDLE, count=0, data_up=0, out_valid=0, underrun=1 for exactly one cycle.
- underrun is 0 on every edge not described above.
- Latency: a symbol accepted at edge k while IDLE appears on data_up with count=1 after edge k+1.
- Throughput:
  - Sustained rate is one symbol per FACTOR cycles.
  - The buffer frees at the load edge, so the source has FACTOR-1 cycles to refill it.
- mode changes mid-symbol take effect only at the next symbol load.
- data_up is never sign-modified; it is the raw WIDTH-bit value or zero.
- Reset or enable deassertion mid-symbol aborts immediately. The buffered symbol is discarded and underrun is not pulsed.

Test Plan:
- FACTOR=4, mode=0; feed symbols 3, -5, 7 back-to-back with in_valid held high.
  - Required: data_up = 3,0,0,0,-5,0,0,0,7,0,0,0.
  - Required: count = 1,2,3,4 repeating, out_valid high throughout.
  - Required: then underrun pulses once, and count=0, out_valid=0.
- mode=1; symbols -8, 7.
  - Required: data_up = -8,-8,-8,-8,7,7,7,7, then 0 with underrun=1.
  - Required: in_ready low from the accept of 7 until its load edge.
- Single symbol 2 accepted at edge k from IDLE.
  - Required: count=1, data_up=2 after edge k+1.
  - Required: underrun=1 after edge k+5; in_ready=1 from edge k+1.
- Flip mode from 0 to 1 at count=2 of symbol 5.
  - Required: remainder of that symbol stays 0; next symbol 6 is emitted as 6,6,6,6.
- Assert rst (or drop enable) at count=3 with the buffer full.
  - Required: next cycle count=0, data_up=0, out_valid=0, underrun=0, buf_full=0.
  - Required: after release, no stale symbol is emitted.
- Source late: the next symbol arrives after the wrap.
  - Required: underrun pulse, one or more idle cycles with count=0.
  - Required: restart at count=1 the edge after buf_full is set.

Source files
------------

// File: rtl/qam16_upsampler.sv
// ---------------------------------------------------------------------------
// qam16_upsampler
//   Transmit-side sample-rate expander for the QAM16 chain. One signed symbol
//   component per symbol period is expanded into FACTOR output samples, in
//   zero-stuff (mode=0) or sample-hold (mode=1) form. A one-entry input
//   buffer with a valid/ready handshake decouples the symbol source from the
//   output sample rate.
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous reset, active-high
//   enable    in   block enable; low flushes the block on the next edge
//   mode      in   0 = zero-stuff, 1 = sample-hold (latched per symbol)
//   in_valid  in   data_in holds a symbol
//   data_in   in   signed symbol component, WIDTH bits
//   in_ready  out  buffer can accept (enable && !buf_full)
//   data_up   out  upsampled sample, registered
//   out_valid out  data_up is a live sample, registered
//   count     out  phase 1..FACTOR while running, 0 when idle, registered
//   underrun  out  one-cycle pulse: a period ended with no next symbol
// ---------------------------------------------------------------------------
module qam16_upsampler #(
  parameter int WIDTH  = 4,
  parameter int FACTOR = 4,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] data_in,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] data_up,
  output logic                    out_valid,
  output logic [CNT_W-1:0]        count,
  output logic                    underrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FACTOR);
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  state_t                   state, state_nxt;
  logic signed [WIDTH-1:0]  buf_data, buf_data_nxt;
  logic                     buf_full, buf_full_nxt;
  logic signed [WIDTH-1:0]  sym, sym_nxt;
  logic                     mode_r, mode_r_nxt;
  logic [CNT_W-1:0]         count_nxt;
  logic signed [WIDTH-1:0]  data_up_nxt;
  logic                     out_valid_nxt;
  logic                     underrun_nxt;
  logic                     load;

  // A full buffer can never accept, so accept and load never share an edge.
  assign in_ready = enable && !buf_full;

  // Next-state and next-output decode for the IDLE/RUN machine and buffer.
  always_comb begin
    state_nxt     = state;
    buf_data_nxt  = buf_data;
    buf_full_nxt  = buf_full;
    sym_nxt       = sym;
    mode_r_nxt    = mode_r;
    count_nxt     = count;
    data_up_nxt   = data_up;
    out_valid_nxt = out_valid;
    underrun_nxt  = 1'b0;
    load          = 1'b0;

    if (!enable) begin
      // Flush: same clearing as reset, buffered symbol discarded, no underrun.
      state_nxt     = IDLE;
      buf_data_nxt  = DATA_ZERO;
      buf_full_nxt  = 1'b0;
      sym_nxt       = DATA_ZERO;
      mode_r_nxt    = 1'b0;
      count_nxt     = CNT_ZERO;
      data_up_nxt   = DATA_ZERO;
      out_valid_nxt = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        buf_data_nxt = data_in;
        buf_full_nxt = 1'b1;
      end else begin
        buf_data_nxt = buf_data;
      end

      case (state)
        IDLE: begin
          count_nxt     = CNT_ZERO;
          data_up_nxt   = DATA_ZERO;
          out_valid_nxt = 1'b0;
          load          = buf_full;
        end
        RUN: begin
          if (count < CNT_LAST) begin
            count_nxt     = count + CNT_ONE;
            out_valid_nxt = 1'b1;
            data_up_nxt   = mode_r ? sym : DATA_ZERO;
          end else if (buf_full) begin
            // Back-to-back symbol: no gap in the output stream.
            load = 1'b1;
          end else begin
            state_nxt     = IDLE;
            count_nxt     = CNT_ZERO;
            data_up_nxt   = DATA_ZERO;
            out_valid_nxt = 1'b0;
            underrun_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt     = IDLE;
          count_nxt     = CNT_ZERO;
          data_up_nxt   = DATA_ZERO;
          out_valid_nxt = 1'b0;
        end
      endcase

      // Symbol load: first sample of a new symbol is always the raw value.
      if (load) begin
        state_nxt     = RUN;
        count_nxt     = CNT_ONE;
        data_up_nxt   = buf_data;
        out_valid_nxt = 1'b1;
        sym_nxt       = buf_data;
        mode_r_nxt    = mode;
        buf_full_nxt  = 1'b0;
      end else begin
        sym_nxt       = sym_nxt;
      end
    end
  end

  // State, buffer and registered outputs; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      buf_data  <= DATA_ZERO;
      buf_full  <= 1'b0;
      sym       <= DATA_ZERO;
      mode_r    <= 1'b0;
      count     <= CNT_ZERO;
      data_up   <= DATA_ZERO;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      buf_data  <= buf_data_nxt;
      buf_full  <= buf_full_nxt;
      sym       <= sym_nxt;
      mode_r    <= mode_r_nxt;
      count     <= count_nxt;
      data_up   <= data_up_nxt;
      out_valid <= out_valid_nxt;
      underrun  <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_qam16_upsampler.sv
// ---------------------------------------------------------------------------
// tb_qam16_upsampler
//   Directed, table-driven bench for qam16_upsampler (WIDTH=4, FACTOR=4).
//   Each table row gives the inputs held across one clock edge, the expected
//   in_ready just before that edge, and the expected registered outputs just
//   after it. A hand-written sustained-stream sequence follows the table.
// ---------------------------------------------------------------------------
module tb_qam16_upsampler;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              mode;
  logic              in_valid;
  logic signed [3:0] data_in;
  logic              in_ready;
  logic signed [3:0] data_up;
  logic              out_valid;
  logic [3:0]        count;
  logic              underrun;

  int applied = 0;
  int miscompares = 0;

  qam16_upsampler #(.WIDTH(4), .FACTOR(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .in_valid(in_valid), .data_in(data_in), .in_ready(in_ready),
    .data_up(data_up), .out_valid(out_valid), .count(count),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic       vld;
    logic [3:0] din;
    logic       chk_rdy;
    logic       rdy;
    logic [3:0] cnt;
    logic [3:0] dat;
    logic       ov;
    logic       ur;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic r, input logic e, input logic m, input logic v,
                     input int d, input logic cr, input logic rd, input int c,
                     input int x, input logic ov, input logic ur);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.vld = v; t.din = 4'(d);
    t.chk_rdy = cr; t.rdy = rd; t.cnt = 4'(c); t.dat = 4'(x);
    t.ov = ov; t.ur = ur;
    vecs.push_back(t);
  endtask

  // Run-mode shorthand: rst=0, enable=1, in_ready always checked.
  task automatic rr(input logic m, input logic v, input int d, input logic rd,
                    input int c, input int x, input logic ov, input logic ur);
    row(1'b0, 1'b1, m, v, d, 1'b1, rd, c, x, ov, ur);
  endtask

  task automatic check_out(input string name, input logic [3:0] c, input logic [3:0] x,
                           input logic ov, input logic ur);
    applied++;
    if (count !== c) begin
      miscompares++;
      $display("FAIL %s count: got %0d expected %0d", name, count, c);
    end
    if (data_up !== x) begin
      miscompares++;
      $display("FAIL %s data_up: got %0d expected %0d", name, data_up, $signed(x));
    end
    if (out_valid !== ov) begin
      miscompares++;
      $display("FAIL %s out_valid: got %b expected %b", name, out_valid, ov);
    end
    if (underrun !== ur) begin
      miscompares++;
      $display("FAIL %s underrun: got %b expected %b", name, underrun, ur);
    end
  endtask

  logic signed [3:0] syms [5];
  int idx;
  logic rdy_s;

  initial begin
    rst = 1'b1; enable = 1'b1; mode = 1'b0; in_valid = 1'b0; data_in = 4'sd0;

    // Reset
    row(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    // Zero-stuff 3, -5, 7 back-to-back, then underrun
    rr(0, 1,  3, 1, 0,  0, 0, 0);
    rr(0, 1, -5, 0, 1,  3, 1, 0);
    rr(0, 1, -5, 1, 2,  0, 1, 0);
    rr(0, 1,  7, 0, 3,  0, 1, 0);
    rr(0, 1,  7, 0, 4,  0, 1, 0);
    rr(0, 1,  7, 0, 1, -5, 1, 0);
    rr(0, 1,  7, 1, 2,  0, 1, 0);
    rr(0, 0,  0, 0, 3,  0, 1, 0);
    rr(0, 0,  0, 0, 4,  0, 1, 0);
    rr(0, 0,  0, 0, 1,  7, 1, 0);
    rr(0, 0,  0, 1, 2,  0, 1, 0);
    rr(0, 0,  0, 1, 3,  0, 1, 0);
    rr(0, 0,  0, 1, 4,  0, 1, 0);
    rr(0, 0,  0, 1, 0,  0, 0, 1);
    rr(0, 0,  0, 1, 0,  0, 0, 0);
    // Sample-hold -8, 7; in_ready low from accept of 7 until its load
    rr(1, 1, -8, 1, 0,  0, 0, 0);
    rr(1, 1,  7, 0, 1, -8, 1, 0);
    rr(1, 1,  7, 1, 2, -8, 1, 0);
    rr(1, 0,  0, 0, 3, -8, 1, 0);
    rr(1, 0,  0, 0, 4, -8, 1, 0);
    rr(1, 0,  0, 0, 1,  7, 1, 0);
    rr(1, 0,  0, 1, 2,  7, 1, 0);
    rr(1, 0,  0, 1, 3,  7, 1, 0);
    rr(1, 0,  0, 1, 4,  7, 1, 0);
    rr(1, 0,  0, 1, 0,  0, 0, 1);
    // Single symbol 2: accept at k, count=1 after k+1, underrun after k+5
    rr(0, 1,  2, 1, 0,  0, 0, 0);
    rr(0, 0,  0, 0, 1,  2, 1, 0);
    rr(0, 0,  0, 1, 2,  0, 1, 0);
    rr(0, 0,  0, 1, 3,  0, 1, 0);
    rr(0, 0,  0, 1, 4,  0, 1, 0);
    rr(0, 0,  0, 1, 0,  0, 0, 1);
    // Mode flip 0->1 during symbol 5; takes effect at symbol 6
    rr(0, 1,  5, 1, 0,  0, 0, 0);
    rr(0, 0,  0, 0, 1,  5, 1, 0);
    rr(1, 1,  6, 1, 2,  0, 1, 0);
    rr(1, 0,  0, 0, 3,  0, 1, 0);
    rr(1, 0,  0, 0, 4,  0, 1, 0);
    rr(1, 0,  0, 0, 1,  6, 1, 0);
    rr(1, 0,  0, 1, 2,  6, 1, 0);
    rr(1, 0,  0, 1, 3,  6, 1, 0);
    rr(1, 0,  0, 1, 4,  6, 1, 0);
    rr(1, 0,  0, 1, 0,  0, 0, 1);
    // Reset at count=3 with buffer full; no stale symbol afterwards
    rr(0, 1,  4, 1, 0,  0, 0, 0);
    rr(0, 0,  0, 0, 1,  4, 1, 0);
    rr(0, 1, -3, 1, 2,  0, 1, 0);
    rr(0, 0,  0, 0, 3,  0, 1, 0);
    row(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    rr(0, 0,  0, 1, 0,  0, 0, 0);
    rr(0, 0,  0, 1, 0,  0, 0, 0);
    // Enable drop at count=3 with buffer full
    rr(1, 1, -1, 1, 0,  0, 0, 0);
    rr(1, 0,  0, 0, 1, -1, 1, 0);
    rr(1, 1,  5, 1, 2, -1, 1, 0);
    rr(1, 0,  0, 0, 3, -1, 1, 0);
    row(1'b0, 1'b0, 1'b1, 1'b1, 6, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    rr(1, 0,  0, 1, 0,  0, 0, 0);
    rr(1, 0,  0, 1, 0,  0, 0, 0);
    // Late source: underrun, idle gap, restart the edge after buf_full set
    rr(0, 1,  1, 1, 0,  0, 0, 0);
    rr(0, 0,  0, 0, 1,  1, 1, 0);
    rr(0, 0,  0, 1, 2,  0, 1, 0);
    rr(0, 0,  0, 1, 3,  0, 1, 0);
    rr(0, 0,  0, 1, 4,  0, 1, 0);
    rr(0, 0,  0, 1, 0,  0, 0, 1);
    rr(0, 1, -2, 1, 0,  0, 0, 0);
    rr(0, 0,  0, 0, 1, -2, 1, 0);
    rr(0, 0,  0, 1, 2,  0, 1, 0);
    rr(0, 0,  0, 1, 3,  0, 1, 0);
    rr(0, 0,  0, 1, 4,  0, 1, 0);
    rr(0, 0,  0, 1, 0,  0, 0, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; enable = vecs[i].en; mode = vecs[i].mode;
      in_valid = vecs[i].vld; data_in = vecs[i].din;
      @(negedge clk);
      if (vecs[i].chk_rdy && (in_ready !== vecs[i].rdy)) begin
        miscompares++;
        $display("FAIL vec%0d in_ready: got %b expected %b", i, in_ready, vecs[i].rdy);
      end
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dat, vecs[i].ov, vecs[i].ur);
    end

    // Sustained sample-hold stream: source refills whenever in_ready is high.
    syms[0] = 4'sd7; syms[1] = -4'sd1; syms[2] = 4'sd0; syms[3] = -4'sd8; syms[4] = 4'sd5;
    idx = 0;
    mode = 1'b1;
    for (int t = 0; t < 23; t++) begin
      in_valid = (idx < 5);
      data_in  = (idx < 5) ? syms[idx] : 4'sd0;
      @(negedge clk);
      rdy_s = in_ready;
      @(posedge clk);
      #1;
      if (rdy_s && (idx < 5)) idx++;
      if (t == 0) begin
        check_out("burst_accept", 4'd0, 4'd0, 1'b0, 1'b0);
      end else if (t <= 20) begin
        check_out($sformatf("burst_t%0d", t), 4'((t - 1) % 4 + 1),
                  syms[(t - 1) / 4], 1'b1, 1'b0);
      end else if (t == 21) begin
        check_out("burst_underrun", 4'd0, 4'd0, 1'b0, 1'b1);
      end else begin
        check_out("burst_idle", 4'd0, 4'd0, 1'b0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
